alsu_cmd_seq: RTL and testbench

Upstream command sequencer for the ALSU datapath. It accepts operation commands over a valid/ready interface and buffers them in a small FIFO. It issues each command to the ALSU input pins for a programmable number of consecutive cycles, which gives multi-step shift/rotate sequences. It also produces result_valid/last/err strobes aligned to the ALSU's registered out/leds.

---
 rtl/alsu_pkg.sv | 46 ++++
 rtl/alsu_cmd_fifo.sv | 58 +++++
 rtl/alsu_cmd_seq.sv | 211 +++++++++++++++++++++
 tb/tb_alsu_cmd_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU command sequencer: opcodes, flag bit positions,
// FSM encoding, ALSU pipeline latency, the command layout and the invalid-op rule.
package alsu_pkg;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_XOR   = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_MUL   = 3'b011;
    localparam logic [2:0] OP_SHIFT = 3'b100;
    localparam logic [2:0] OP_ROT   = 3'b101;

    // Bit positions inside the 7-bit flag field {cin, SI, sh_left, red_op_A, red_op_B, pass_A, pass_B}
    localparam int FLAG_W       = 7;
    localparam int FLAG_CIN     = 6;
    localparam int FLAG_SI      = 5;
    localparam int FLAG_SH_LEFT = 4;
    localparam int FLAG_RED_A   = 3;
    localparam int FLAG_RED_B   = 2;
    localparam int FLAG_PASS_A  = 1;
    localparam int FLAG_PASS_B  = 0;

    localparam int ALSU_LAT = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } seq_state_t;

    // Command layout at the default widths (BITS=3, CNT_W=4)
    localparam int CMD_BITS  = 3;
    localparam int CMD_CNT_W = 4;

    typedef struct packed {
        logic [2:0]           opcode;
        logic [CMD_BITS-1:0]  a;
        logic [CMD_BITS-1:0]  b;
        logic [FLAG_W-1:0]    flags;
        logic [CMD_CNT_W-1:0] rpt;
    } alsu_cmd_t;

    function automatic logic alsu_inv(input logic [2:0] op, input logic [FLAG_W-1:0] flags);
        return (op[2:1] == 2'b11) ||
               ((flags[FLAG_RED_A] | flags[FLAG_RED_B]) && (op[2] | op[1]));
    endfunction

endpackage

// File: rtl/alsu_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; exposes the head entry and the
// one behind it so the sequencer can chain commands without a bubble.
module alsu_cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             head,
    output logic [W-1:0]             head_next,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + AW'(1)];
    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);

endmodule

// File: rtl/alsu_cmd_seq.sv
// Command sequencer in front of the ALSU: buffers commands, replays each for its
// repeat count, and emits result strobes aligned to the ALSU's registered output.
// Optional: ALSU_SEQ_DROP_INVALID_EN drops invalid commands instead of issuing them.
module alsu_cmd_seq
    import alsu_pkg::*;
#(
    parameter int BITS  = 3,
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_opcode,
    input  logic [BITS-1:0]  cmd_a,
    input  logic [BITS-1:0]  cmd_b,
    input  logic [6:0]       cmd_flags,
    input  logic [CNT_W-1:0] cmd_repeat,
    input  logic             hold,
    output logic [2:0]       opcode,
    output logic [BITS-1:0]  A,
    output logic [BITS-1:0]  B,
    output logic             cin,
    output logic             SI,
    output logic             sh_left,
    output logic             red_op_A,
    output logic             red_op_B,
    output logic             pass_A,
    output logic             pass_B,
    output logic             busy,
    output logic             result_valid,
    output logic             result_last,
    output logic             result_err
);

    localparam int CW = $clog2(DEPTH) + 1;

`ifdef ALSU_SEQ_DROP_INVALID_EN
    localparam bit DROP_INV = 1'b1;
`else
    localparam bit DROP_INV = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]        opcode;
        logic [BITS-1:0]   a;
        logic [BITS-1:0]   b;
        logic [FLAG_W-1:0] flags;
        logic [CNT_W-1:0]  rpt;
    } cmd_t;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [BITS-1:0]   a;
        logic [BITS-1:0]   b;
        logic [FLAG_W-1:0] flags;
    } drive_t;

    localparam int     CMD_W = $bits(cmd_t);
    localparam drive_t NOP   = '{opcode: OP_AND, a: '0, b: '0, flags: '0};

    cmd_t          cmd_in;
    cmd_t          head;
    cmd_t          head_next;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          pop;

    seq_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    drive_t           drv, drv_n;

    function automatic drive_t to_drive(input cmd_t c);
        return {c.opcode, c.a, c.b, c.flags};
    endfunction

    // A repeat of 0 runs once, same as 1
    function automatic logic [CNT_W-1:0] first_cnt(input logic [CNT_W-1:0] r);
        return (r == '0) ? '0 : r - CNT_W'(1);
    endfunction

    assign cmd_in = {cmd_opcode, cmd_a, cmd_b, cmd_flags, cmd_repeat};

    alsu_cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en     (cmd_valid && !full),
        .wr_data   (cmd_in),
        .rd_en     (pop),
        .head      (head),
        .head_next (head_next),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    logic head_inv;
    logic next_inv;

    assign head_inv = alsu_inv(head.opcode, head.flags);
    assign next_inv = alsu_inv(head_next.opcode, head_next.flags);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        drv_n   = drv;
        pop     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                drv_n = NOP;
                if (!empty && !hold) begin
                    if (DROP_INV && head_inv) begin
                        pop = 1'b1;
                    end else begin
                        state_n = ST_ISSUE;
                        drv_n   = to_drive(head);
                        cnt_n   = first_cnt(head.rpt);
                    end
                end
            end
            ST_ISSUE: begin
                // hold is only honoured here, at the end of a command's repeat run
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    pop = 1'b1;
                    if (count >= CW'(2) && !hold && !(DROP_INV && next_inv)) begin
                        drv_n = to_drive(head_next);
                        cnt_n = first_cnt(head_next.rpt);
                    end else begin
                        state_n = ST_IDLE;
                        drv_n   = NOP;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                drv_n   = NOP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            cnt   <= '0;
            drv   <= NOP;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            drv   <= drv_n;
        end
    end

    logic issue_v;

    assign issue_v = (state == ST_ISSUE);

    // Strobe pipeline: one stage for the ALSU input FFs, one for its out_reg
    logic [ALSU_LAT-1:0] v_pipe;
    logic [ALSU_LAT-1:0] l_pipe;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_pipe <= '0;
            l_pipe <= '0;
        end else begin
            v_pipe <= {v_pipe[ALSU_LAT-2:0], issue_v};
            l_pipe <= {l_pipe[ALSU_LAT-2:0], issue_v && (cnt == '0)};
        end
    end

    assign result_valid = v_pipe[ALSU_LAT-1];
    assign result_last  = l_pipe[ALSU_LAT-1];

`ifdef ALSU_SEQ_DROP_INVALID_EN
    assign result_err = 1'b0;
`else
    logic [ALSU_LAT-1:0] e_pipe;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            e_pipe <= '0;
        end else begin
            e_pipe <= {e_pipe[ALSU_LAT-2:0], issue_v && alsu_inv(drv.opcode, drv.flags)};
        end
    end

    assign result_err = e_pipe[ALSU_LAT-1];
`endif

    assign opcode    = drv.opcode;
    assign A         = drv.a;
    assign B         = drv.b;
    assign cin       = drv.flags[FLAG_CIN];
    assign SI        = drv.flags[FLAG_SI];
    assign sh_left   = drv.flags[FLAG_SH_LEFT];
    assign red_op_A  = drv.flags[FLAG_RED_A];
    assign red_op_B  = drv.flags[FLAG_RED_B];
    assign pass_A    = drv.flags[FLAG_PASS_A];
    assign pass_B    = drv.flags[FLAG_PASS_B];

    assign busy      = !empty || issue_v;
    assign cmd_ready = !full;

endmodule

// File: tb/tb_alsu_cmd_seq.sv
// Directed bench for alsu_cmd_seq: per-cycle pattern checks plus a scoreboard that
// matches every result strobe to the command that was on the ALSU pins 2 cycles earlier.
module tb_alsu_cmd_seq;
    import alsu_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_opcode = '0;
    logic [2:0] cmd_a = '0;
    logic [2:0] cmd_b = '0;
    logic [6:0] cmd_flags = '0;
    logic [3:0] cmd_repeat = '0;
    logic       hold = 1'b0;
    logic [2:0] opcode;
    logic [2:0] A;
    logic [2:0] B;
    logic       cin, SI, sh_left, red_op_A, red_op_B, pass_A, pass_B;
    logic       busy, result_valid, result_last, result_err;

    int total = 0;
    int bad   = 0;

    // {opcode, a, b, flags, last, err}
    logic [17:0] exp_q[$];
    logic [15:0] hist1 = '0;
    logic [15:0] hist2 = '0;

    always #5 clk = ~clk;

    alsu_cmd_seq dut (
        .clk          (clk),
        .rstn         (rstn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_flags    (cmd_flags),
        .cmd_repeat   (cmd_repeat),
        .hold         (hold),
        .opcode       (opcode),
        .A            (A),
        .B            (B),
        .cin          (cin),
        .SI           (SI),
        .sh_left      (sh_left),
        .red_op_A     (red_op_A),
        .red_op_B     (red_op_B),
        .pass_A       (pass_A),
        .pass_B       (pass_B),
        .busy         (busy),
        .result_valid (result_valid),
        .result_last  (result_last),
        .result_err   (result_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                        input logic [6:0] flags, input logic [3:0] rpt, input logic err);
        int n;
        int reps;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_flags  = flags;
        cmd_repeat = rpt;
        cmd_valid  = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick;
            n++;
        end
        if (!cmd_ready) begin
            check("push_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        tick;
        cmd_valid = 1'b0;
        reps = (rpt == 4'd0) ? 1 : int'(rpt);
`ifdef ALSU_SEQ_DROP_INVALID_EN
        if (err) return;
`endif
        for (int i = 0; i < reps; i++) begin
            exp_q.push_back({op, a, b, flags, (i == reps - 1), err});
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [15:0] cur;
        logic [17:0] e;
        cur = {opcode, A, B, cin, SI, sh_left, red_op_A, red_op_B, pass_A, pass_B};
        if (result_valid) begin
            if (exp_q.size() == 0) begin
                check("extra_result", 32'(result_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_result", 32'({hist2, result_last, result_err}), 32'(e));
            end
        end else if (result_last || result_err) begin
            check("stray_strobe", 32'({result_last, result_err}), 32'd0);
        end
        hist2 = hist1;
        hist1 = cur;
    end

    initial begin
        logic [5:0] got_iss, got_rv, got_rl;
        logic [7:0] t3_exp [7];
        logic [6:0] t4_exp [9];
        logic [4:0] t5_rv, t5_err;
        logic       seen;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pins", 32'({opcode, A, B, cin, SI, sh_left, red_op_A, red_op_B, pass_A, pass_B}), 32'd0);
        check("rst_strobes", 32'({result_valid, result_last, result_err}), 32'd0);
        rstn = 1'b1;
        tick;

        // single AND, repeat 1
        push(OP_AND, 3'd5, 3'd3, 7'd0, 4'd1, 1'b0);
        check("t1_c1", 32'({busy, opcode, A}), 32'({1'b1, 3'b000, 3'd0}));
        tick;
        check("t1_issue", 32'({opcode, A, B}), 32'({3'b000, 3'd5, 3'd3}));
        tick;
        check("t1_nop", 32'({A, B, result_valid}), 32'd0);
        tick;
        check("t1_result", 32'({result_valid, result_last, result_err}), 32'b110);
        tick;
        check("t1_done", 32'({result_valid, busy}), 32'd0);
        repeat (3) tick;

        // SHIFT left with SI, repeat 3
        push(OP_SHIFT, 3'd6, 3'd0, 7'b0110000, 4'd3, 1'b0);
        tick;
        for (int i = 0; i < 6; i++) begin
            got_iss[i] = (opcode == OP_SHIFT) && (A == 3'd6) && SI && sh_left;
            got_rv[i]  = result_valid;
            got_rl[i]  = result_last;
            tick;
        end
        check("t2_issue", 32'(got_iss), 32'(6'b000111));
        check("t2_rvalid", 32'(got_rv), 32'(6'b011100));
        check("t2_rlast", 32'(got_rl), 32'(6'b010000));
        repeat (3) tick;

        // fill under hold, refuse the fifth, then drain back-to-back
        hold = 1'b1;
        push(OP_XOR, 3'd1, 3'd2, 7'd0, 4'd1, 1'b0);
        push(OP_ADD, 3'd3, 3'd4, 7'd0, 4'd0, 1'b0);
        push(OP_MUL, 3'd2, 3'd3, 7'd0, 4'd1, 1'b0);
        push(OP_AND, 3'd7, 3'd7, 7'd0, 4'd1, 1'b0);
        check("t3_full", 32'({cmd_ready, busy, opcode, A}), 32'({1'b0, 1'b1, 3'b000, 3'd0}));
        cmd_opcode = OP_ROT;
        cmd_a      = 3'd1;
        cmd_valid  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seen |= cmd_ready;
            tick;
        end
        cmd_valid = 1'b0;
        check("t3_refused", 32'(seen), 32'd0);
        t3_exp = '{8'b0_0_001_001, 8'b1_0_010_011, 8'b1_1_011_010, 8'b1_1_000_111,
                   8'b1_1_000_000, 8'b1_1_000_000, 8'b1_0_000_000};
        hold = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick;
            check($sformatf("t3_d%0d", i + 1), 32'({cmd_ready, result_valid, opcode, A}), 32'(t3_exp[i]));
        end
        repeat (3) tick;

        // hold raised during a repeat-4 rotate
        push(OP_ROT, 3'd5, 3'd0, 7'd0, 4'd4, 1'b0);
        push(OP_AND, 3'd1, 3'd1, 7'd0, 4'd1, 1'b0);
        hold = 1'b1;
        t4_exp = '{7'b1_101_101, 7'b1_101_101, 7'b1_101_101, 7'b1_101_101,
                   7'b1_000_000, 7'b1_000_000, 7'b1_000_000, 7'b1_000_001, 7'b0_000_000};
        for (int i = 0; i < 9; i++) begin
            check($sformatf("t4_c%0d", i), 32'({busy, opcode, A}), 32'(t4_exp[i]));
            if (i == 6) hold = 1'b0;
            tick;
        end
        repeat (3) tick;

        // invalid opcode 110, ADD with a reduction flag, XOR with a reduction flag
        push(3'b110, 3'd2, 3'd1, 7'd0, 4'd1, 1'b1);
        push(OP_ADD, 3'd1, 3'd1, 7'b0000100, 4'd1, 1'b1);
        push(OP_XOR, 3'd2, 3'd2, 7'b0001000, 4'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            t5_rv[i]  = result_valid;
            t5_err[i] = result_err;
            tick;
        end
`ifdef ALSU_SEQ_DROP_INVALID_EN
        check("t5_rvalid", 32'(t5_rv), 32'(5'b01000));
        check("t5_err", 32'(t5_err), 32'(5'b00000));
`else
        check("t5_rvalid", 32'(t5_rv), 32'(5'b01110));
        check("t5_err", 32'(t5_err), 32'(5'b00110));
`endif
        repeat (3) tick;

        // asynchronous reset in the middle of a repeat run
        push(OP_SHIFT, 3'd3, 3'd0, 7'b0010000, 4'd5, 1'b0);
        push(OP_XOR, 3'd1, 3'd1, 7'd0, 4'd1, 1'b0);
        tick;
        check("t6_pre", 32'({busy, opcode}), 32'({1'b1, 3'b100}));
        rstn = 1'b0;
        exp_q.delete();
        #1;
        check("t6_pins", 32'({opcode, A, B, cin, SI, sh_left, red_op_A, red_op_B, pass_A, pass_B}), 32'd0);
        check("t6_ready_busy", 32'({cmd_ready, busy, result_valid}), 32'b100);
        repeat (2) tick;
        rstn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            seen |= result_valid | result_last | result_err | busy;
        end
        check("t6_quiet", 32'(seen), 32'd0);

        // still functional after reset
        push(OP_AND, 3'd2, 3'd6, 7'b1000000, 4'd2, 1'b0);
        repeat (8) tick;
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        check("global_timeout", 32'd1, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
